// File: rtl/gu_mod_counter.sv
// gu_mod_counter -- modulo-N up/down counter with programmable step,
// wrap/saturate boundary handling, built-in prescaler, parallel load,
// one-cycle terminal-count pulse and sticky overflow flag.
//
// Parameters:
//   BITS     counter width
//   MODULO   count stays within 0..MODULO-1 (2 <= MODULO <= 2**BITS)
//   STEP     amount added/subtracted per advance (1 <= STEP < MODULO)
//   SATURATE 0 = wrap at the boundary, 1 = clamp at the boundary
//   PRESCALE enabled cycles per advance (>= 1)
//
// Ports:
//   clk          clock, all state on the rising edge
//   reset_in[1]  asynchronous active-high reset
//   reset_in[0]  synchronous active-high clear
//   enable       prescaler/counter advance enable; low holds state
//   up_down      1 = count up, 0 = count down
//   load         synchronous parallel load (clamped to MODULO-1)
//   load_value   value written on load
//   clear_flags  synchronous clear of overflow (a boundary event wins)
//   count        registered count
//   tc           registered one-cycle terminal-count pulse
//   overflow     registered sticky boundary-event flag
//
// Optional feature, macro GU_MOD_COUNTER_COMPARE_EN:
//   cmp_value    compare value
//   cmp_match    registered, high when the new count equals cmp_value
module gu_mod_counter #(
    parameter int BITS     = 10,
    parameter int MODULO   = 1000,
    parameter int STEP     = 1,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic            clk,
    input  logic [1:0]      reset_in,
    input  logic            enable,
    input  logic            up_down,
    input  logic            load,
    input  logic [BITS-1:0] load_value,
    input  logic            clear_flags,
`ifdef GU_MOD_COUNTER_COMPARE_EN
    input  logic [BITS-1:0] cmp_value,
    output logic            cmp_match,
`endif
    output logic [BITS-1:0] count,
    output logic            tc,
    output logic            overflow
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // All count arithmetic is done one bit wider than the count so that
    // count+STEP and MODULO itself are representable without truncation.
    localparam logic [BITS:0] MOD_C      = (BITS+1)'(MODULO);
    localparam logic [BITS:0] TOP_C      = (BITS+1)'(MODULO - 1);
    localparam logic [BITS:0] STEP_C     = (BITS+1)'(STEP);
    localparam logic [PW-1:0] PRE_LAST_C = PW'(PRESCALE - 1);

    logic            arst_s;
    logic [BITS-1:0] count_r;
    logic [BITS-1:0] count_nxt_s;
    logic [PW-1:0]   presc_r;
    logic [PW-1:0]   presc_nxt_s;
    logic            tc_r;
    logic            overflow_r;
    logic            overflow_nxt_s;
    logic            bnd_s;
    logic [BITS:0]   cnt_ext_s;
    logic [BITS:0]   sum_s;
    logic [BITS:0]   load_ext_s;
    logic [BITS:0]   ext_nxt_s;

    assign arst_s   = reset_in[1];
    assign count    = count_r;
    assign tc       = tc_r;
    assign overflow = overflow_r;

    // Next-state: sync clear > load > advance > hold, plus boundary detection.
    always_comb begin
        cnt_ext_s      = {1'b0, count_r};
        sum_s          = cnt_ext_s + STEP_C;
        load_ext_s     = {1'b0, load_value};
        ext_nxt_s      = cnt_ext_s;
        count_nxt_s    = count_r;
        presc_nxt_s    = presc_r;
        bnd_s          = 1'b0;
        overflow_nxt_s = overflow_r;

        if (reset_in[0]) begin
            count_nxt_s = {BITS{1'b0}};
            presc_nxt_s = {PW{1'b0}};
        end else if (load) begin
            count_nxt_s = (load_ext_s > TOP_C) ? TOP_C[BITS-1:0] : load_value;
            presc_nxt_s = {PW{1'b0}};
        end else if (enable) begin
            if (presc_r == PRE_LAST_C) begin
                presc_nxt_s = {PW{1'b0}};
                if (up_down) begin
                    if (sum_s <= TOP_C) begin
                        ext_nxt_s = sum_s;
                    end else begin
                        bnd_s     = 1'b1;
                        ext_nxt_s = (SATURATE != 0) ? TOP_C : (sum_s - MOD_C);
                    end
                end else begin
                    if (cnt_ext_s >= STEP_C) begin
                        ext_nxt_s = cnt_ext_s - STEP_C;
                    end else begin
                        bnd_s     = 1'b1;
                        ext_nxt_s = (SATURATE != 0) ? {(BITS+1){1'b0}}
                                                    : (cnt_ext_s + MOD_C - STEP_C);
                    end
                end
                count_nxt_s = ext_nxt_s[BITS-1:0];
            end else begin
                presc_nxt_s = presc_r + PW'(1);
            end
        end else begin
            presc_nxt_s = presc_r;
        end

        // Overflow: sync clear drops it, a boundary event sets it and
        // outranks a coincident clear_flags.
        if (reset_in[0]) begin
            overflow_nxt_s = 1'b0;
        end else if (bnd_s) begin
            overflow_nxt_s = 1'b1;
        end else if (clear_flags) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge arst_s) begin
        if (arst_s) begin
            count_r    <= {BITS{1'b0}};
            presc_r    <= {PW{1'b0}};
            tc_r       <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            count_r    <= count_nxt_s;
            presc_r    <= presc_nxt_s;
            tc_r       <= bnd_s;
            overflow_r <= overflow_nxt_s;
        end
    end

`ifdef GU_MOD_COUNTER_COMPARE_EN
    logic cmp_match_r;

    assign cmp_match = cmp_match_r;

    // Compare against the next count so the match is aligned with count.
    always_ff @(posedge clk or posedge arst_s) begin
        if (arst_s) begin
            cmp_match_r <= 1'b0;
        end else if (reset_in[0]) begin
            cmp_match_r <= 1'b0;
        end else begin
            cmp_match_r <= (count_nxt_s == cmp_value);
        end
    end
`endif

endmodule

// File: tb/tb_gu_mod_counter.sv
// Self-checking bench for gu_mod_counter: several parameterisations driven
// by shared inputs, each tracked by an arithmetic reference model, plus a
// vector table and directed sequences for the corner cases.
module tb_gu_mod_counter;

    localparam int N = 5;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic       en, ud, ld, clr;
    logic [9:0] lv;
    logic [9:0] c0, c3;
    logic [3:0] c1, c2;
    logic [2:0] c4;
    logic [N-1:0] tcv, ovv;
`ifdef GU_MOD_COUNTER_COMPARE_EN
    logic [9:0]   cmpv;
    logic [N-1:0] cmpm;
    bit           m_cm [N];
`endif

    int total = 0;
    int bad   = 0;

    // Reference model parameters and state
    int m_mod  [N] = '{1000, 10, 10, 1000, 8};
    int m_stp  [N] = '{1, 3, 3, 1, 5};
    int m_sat  [N] = '{0, 0, 1, 0, 0};
    int m_pre  [N] = '{1, 1, 1, 4, 3};
    int m_bits [N] = '{10, 4, 4, 10, 3};
    int m_cnt  [N];
    int m_ph   [N];
    bit m_tc   [N];
    bit m_ovf  [N];

    always #5 clk = ~clk;

    gu_mod_counter #(.BITS(10), .MODULO(1000), .STEP(1), .SATURATE(0), .PRESCALE(1)) u_def (
        .clk(clk), .reset_in(rst), .enable(en), .up_down(ud), .load(ld),
        .load_value(lv), .clear_flags(clr),
`ifdef GU_MOD_COUNTER_COMPARE_EN
        .cmp_value(cmpv), .cmp_match(cmpm[0]),
`endif
        .count(c0), .tc(tcv[0]), .overflow(ovv[0]));

    gu_mod_counter #(.BITS(4), .MODULO(10), .STEP(3), .SATURATE(0), .PRESCALE(1)) u_wrap (
        .clk(clk), .reset_in(rst), .enable(en), .up_down(ud), .load(ld),
        .load_value(lv[3:0]), .clear_flags(clr),
`ifdef GU_MOD_COUNTER_COMPARE_EN
        .cmp_value(cmpv[3:0]), .cmp_match(cmpm[1]),
`endif
        .count(c1), .tc(tcv[1]), .overflow(ovv[1]));

    gu_mod_counter #(.BITS(4), .MODULO(10), .STEP(3), .SATURATE(1), .PRESCALE(1)) u_sat (
        .clk(clk), .reset_in(rst), .enable(en), .up_down(ud), .load(ld),
        .load_value(lv[3:0]), .clear_flags(clr),
`ifdef GU_MOD_COUNTER_COMPARE_EN
        .cmp_value(cmpv[3:0]), .cmp_match(cmpm[2]),
`endif
        .count(c2), .tc(tcv[2]), .overflow(ovv[2]));

    gu_mod_counter #(.BITS(10), .MODULO(1000), .STEP(1), .SATURATE(0), .PRESCALE(4)) u_pre (
        .clk(clk), .reset_in(rst), .enable(en), .up_down(ud), .load(ld),
        .load_value(lv), .clear_flags(clr),
`ifdef GU_MOD_COUNTER_COMPARE_EN
        .cmp_value(cmpv), .cmp_match(cmpm[3]),
`endif
        .count(c3), .tc(tcv[3]), .overflow(ovv[3]));

    gu_mod_counter #(.BITS(3), .MODULO(8), .STEP(5), .SATURATE(0), .PRESCALE(3)) u_full (
        .clk(clk), .reset_in(rst), .enable(en), .up_down(ud), .load(ld),
        .load_value(lv[2:0]), .clear_flags(clr),
`ifdef GU_MOD_COUNTER_COMPARE_EN
        .cmp_value(cmpv[2:0]), .cmp_match(cmpm[4]),
`endif
        .count(c4), .tc(tcv[4]), .overflow(ovv[4]));

    typedef struct {
        logic [1:0] r;
        logic       l;
        logic [9:0] v;
        logic       e;
        logic       u;
        logic       c;
        int         cnt;
        logic       t;
        logic       o;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic [1:0] r, input logic l, input logic [9:0] v,
                                input logic e, input logic u, input logic c,
                                input int n, input logic t, input logic o);
        vec_t x;
        x.r = r; x.l = l; x.v = v; x.e = e; x.u = u; x.c = c;
        x.cnt = n; x.t = t; x.o = o;
        return x;
    endfunction

    function automatic logic [31:0] dut_cnt(input int i);
        case (i)
            0: return {22'd0, c0};
            1: return {28'd0, c1};
            2: return {28'd0, c2};
            3: return {22'd0, c3};
            4: return {29'd0, c4};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_async();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
`ifdef GU_MOD_COUNTER_COMPARE_EN
            m_cm[i] = 1'b0;
`endif
        end
    endtask

    // One clock edge of the behavioural model, using the current inputs
    task automatic model_edge();
        int v;
        int n;
        bit b;
        for (int i = 0; i < N; i++) begin
            if (rst[0]) begin
                m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
            end else if (ld) begin
                v = int'(lv) % (1 << m_bits[i]);
                m_cnt[i] = (v > m_mod[i] - 1) ? m_mod[i] - 1 : v;
                m_ph[i]  = 0;
                m_tc[i]  = 1'b0;
                if (clr) m_ovf[i] = 1'b0;
            end else begin
                b = 1'b0;
                if (en) begin
                    if (m_ph[i] == m_pre[i] - 1) begin
                        m_ph[i] = 0;
                        n = ud ? m_cnt[i] + m_stp[i] : m_cnt[i] - m_stp[i];
                        if (n >= m_mod[i]) begin
                            b = 1'b1;
                            n = (m_sat[i] != 0) ? m_mod[i] - 1 : n - m_mod[i];
                        end else if (n < 0) begin
                            b = 1'b1;
                            n = (m_sat[i] != 0) ? 0 : n + m_mod[i];
                        end
                        m_cnt[i] = n;
                    end else begin
                        m_ph[i]++;
                    end
                end
                m_tc[i] = b;
                if (b) m_ovf[i] = 1'b1;
                else if (clr) m_ovf[i] = 1'b0;
            end
`ifdef GU_MOD_COUNTER_COMPARE_EN
            m_cm[i] = rst[0] ? 1'b0 : (m_cnt[i] == int'(cmpv) % (1 << m_bits[i]));
`endif
        end
    endtask

    task automatic check_models(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s.cnt%0d", tag, i), dut_cnt(i), m_cnt[i]);
            chk($sformatf("%s.tc%0d", tag, i), {31'd0, tcv[i]}, {31'd0, m_tc[i]});
            chk($sformatf("%s.ovf%0d", tag, i), {31'd0, ovv[i]}, {31'd0, m_ovf[i]});
`ifdef GU_MOD_COUNTER_COMPARE_EN
            chk($sformatf("%s.cmp%0d", tag, i), {31'd0, cmpm[i]}, {31'd0, m_cm[i]});
`endif
        end
    endtask

    // Inputs are already set; clock once, then compare every instance
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_models(tag);
    endtask

    initial begin
        rst = 2'b10; en = 1'b0; ud = 1'b1; ld = 1'b0; clr = 1'b0; lv = 10'd0;
`ifdef GU_MOD_COUNTER_COMPARE_EN
        cmpv = 10'd3;
`endif
        model_async();
        repeat (2) @(posedge clk);
        #1;
        check_models("por");
        rst = 2'b00;

        // Asynchronous reset between edges
        ld = 1'b1; lv = 10'd37;
        step("ld37");
        ld = 1'b0;
        chk("def_ld37", {22'd0, c0}, 32'd37);
        #2;
        rst = 2'b10;
        #1;
        model_async();
        chk("arst_cnt", {22'd0, c0}, 32'd0);
        chk("arst_tc", {31'd0, tcv[0]}, 32'd0);
        chk("arst_ovf", {31'd0, ovv[0]}, 32'd0);
        check_models("arst");
        #1;
        rst = 2'b00; en = 1'b1; ud = 1'b1;
        step("arst_rel");
        chk("arst_first_adv", {22'd0, c0}, 32'd1);

        // Wrap-mode vector table (checked on the MODULO=10, STEP=3 instance)
        tbl.push_back(mk(2'b01, 1'b1, 10'd5, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 1'b1, 10'd8, 1'b1, 1'b1, 1'b0, 8, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1));
        tbl.push_back(mk(2'b00, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b1));
        tbl.push_back(mk(2'b00, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 7, 1'b0, 1'b1));
        tbl.push_back(mk(2'b00, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1));
        tbl.push_back(mk(2'b00, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b1));
        tbl.push_back(mk(2'b00, 1'b1, 10'd1, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b1));
        tbl.push_back(mk(2'b00, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 8, 1'b1, 1'b1));
        tbl.push_back(mk(2'b00, 1'b0, 10'd0, 1'b1, 1'b0, 1'b1, 5, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 1'b0, 10'd0, 1'b1, 1'b0, 1'b1, 9, 1'b1, 1'b1));
        for (int k = 0; k < tbl.size(); k++) begin
            rst = tbl[k].r; ld = tbl[k].l; lv = tbl[k].v;
            en = tbl[k].e; ud = tbl[k].u; clr = tbl[k].c;
            step($sformatf("tbl%0d", k));
            chk($sformatf("tbl%0d_cnt", k), {28'd0, c1}, tbl[k].cnt);
            chk($sformatf("tbl%0d_tc", k), {31'd0, tcv[1]}, {31'd0, tbl[k].t});
            chk($sformatf("tbl%0d_ovf", k), {31'd0, ovv[1]}, {31'd0, tbl[k].o});
        end
        rst = 2'b00; clr = 1'b0;

        // Saturate: clamp at the top repeatedly, then clamp at zero
        ld = 1'b1; lv = 10'd8; en = 1'b1; ud = 1'b1;
        step("sat_ld");
        ld = 1'b0;
        step("sat_up1");
        chk("sat_up1_cnt", {28'd0, c2}, 32'd9);
        chk("sat_up1_tc", {31'd0, tcv[2]}, 32'd1);
        step("sat_up2");
        chk("sat_up2_cnt", {28'd0, c2}, 32'd9);
        chk("sat_up2_tc", {31'd0, tcv[2]}, 32'd1);
        ld = 1'b1; lv = 10'd2;
        step("sat_ld2");
        ld = 1'b0; ud = 1'b0;
        step("sat_dn");
        chk("sat_dn_cnt", {28'd0, c2}, 32'd0);
        chk("sat_dn_tc", {31'd0, tcv[2]}, 32'd1);

        // Prescaler: 12 enabled edges give 3 advances, enable low holds phase
        rst = 2'b01;
        step("pre_clr");
        rst = 2'b00; ud = 1'b1; en = 1'b1;
        repeat (12) step("pre_run");
        chk("pre_12", {22'd0, c3}, 32'd3);
        repeat (2) step("pre_half");
        en = 1'b0;
        repeat (2) step("pre_hold");
        chk("pre_hold_cnt", {22'd0, c3}, 32'd3);
        en = 1'b1;
        step("pre_p3");
        chk("pre_p3_cnt", {22'd0, c3}, 32'd3);
        step("pre_adv");
        chk("pre_adv_cnt", {22'd0, c3}, 32'd4);

        // Load clamp and load coincident with an advancing edge
        ld = 1'b1; lv = 10'd1023;
        step("clamp");
        chk("clamp_cnt", {22'd0, c0}, 32'd999);
        ld = 1'b0;
        repeat (3) step("pre_fill");
        ld = 1'b1; lv = 10'd500;
        step("ld_adv");
        chk("ld_adv_cnt", {22'd0, c3}, 32'd500);
        ld = 1'b0;
        repeat (3) step("ld_phase");
        chk("ld_phase_cnt", {22'd0, c3}, 32'd500);
        step("ld_next");
        chk("ld_next_cnt", {22'd0, c3}, 32'd501);

        // Randomized run against the reference model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(199) == 0) begin
                rst = 2'b10;
                #2;
                model_async();
                check_models("rnd_arst");
                rst = 2'b00;
            end
            rst = ($urandom_range(63) == 0) ? 2'b01 : 2'b00;
            ld  = ($urandom_range(15) == 0);
            en  = ($urandom_range(3) != 0);
            ud  = $urandom_range(1) == 1;
            clr = ($urandom_range(7) == 0);
            lv  = 10'($urandom);
`ifdef GU_MOD_COUNTER_COMPARE_EN
            if ($urandom_range(31) == 0) cmpv = 10'($urandom_range(9));
`endif
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
